// File: rtl/posit_encode_3_es2.sv
// rtl/posit_encode_3_es2.sv - packs a raw posit sum record into an es=2 posit
// Three register stages: regime/exponent split, bit-vector build, RNE and saturation.
module posit_encode_3_es2 #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int FBITS = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FBITS+10:0]  in_sum,
  output logic [NBITS-1:0]   result,
  output logic               done
);

  localparam int KW  = 8 - ES;
  localparam int VW  = 2 * NBITS + 2;
  localparam int PAD = VW - 2 - ES - FBITS;
  localparam logic signed [KW-1:0] K_HI = KW'(NBITS - 2);
  localparam logic signed [KW-1:0] K_LO = -K_HI;

  logic              v1_q, v2_q, done_q;
  logic [NBITS-1:0]  result_q, result_d;

  // stage 1 decode
  logic signed [7:0]    scale;
  logic signed [KW-1:0] k_raw, k_d;
  logic                 hi_d, lo_d;

  logic                 sgn1_q, inf1_q, zero1_q, hi1_q, lo1_q;
  logic signed [KW-1:0] k1_q;
  logic [ES-1:0]        e1_q;
  logic [FBITS-1:0]     frac1_q;

  assign scale = in_sum[FBITS+9:FBITS+2];
  // the upper scale bits are exactly scale >>> ES
  assign k_raw = scale[7:ES];

  always_comb begin
    hi_d = 1'b0;
    lo_d = 1'b0;
    k_d  = k_raw;
    if (k_raw > K_HI) begin
      hi_d = 1'b1;
      k_d  = K_HI;
    end else if (k_raw < K_LO) begin
      lo_d = 1'b1;
      k_d  = K_LO;
    end
  end

  // stage 2 vector build
  logic [KW-2:0]          shamt;
  logic signed [VW-1:0]   seed, vec;
  logic [NBITS-2:0]       mag_d;
  logic                   guard_d, sticky_d;

  logic                   sgn2_q, inf2_q, zero2_q, hi2_q, lo2_q;
  logic [NBITS-2:0]       mag2_q;
  logic                   guard2_q, sticky2_q;

  // Seed is "10" for k>=0 and "01" for k<0; the arithmetic shift replicates the
  // leading bit so the regime grows to k+1 ones or -k zeros before its terminator.
  always_comb begin
    shamt    = k1_q[KW-1] ? ~k1_q[KW-2:0] : k1_q[KW-2:0];
    seed     = {~k1_q[KW-1], k1_q[KW-1], e1_q, frac1_q, {PAD{1'b0}}};
    vec      = seed >>> shamt;
    mag_d    = vec[VW-1 -: NBITS-1];
    guard_d  = vec[VW-NBITS];
    sticky_d = |vec[VW-NBITS-1:0];
  end

  // stage 3 rounding and packing
  logic [NBITS-2:0] mag_r;
  logic [NBITS-1:0] pos;
  logic             inc;

  always_comb begin
    inc   = guard2_q & (mag2_q[0] | sticky2_q) & ~(&mag2_q);
    mag_r = mag2_q + {{(NBITS-2){1'b0}}, inc};
    if (mag_r == '0) mag_r = {{(NBITS-2){1'b0}}, 1'b1};
    if (hi2_q)       mag_r = '1;
    if (lo2_q)       mag_r = {{(NBITS-2){1'b0}}, 1'b1};
    pos      = {1'b0, mag_r};
    result_d = sgn2_q ? -pos : pos;
    if (inf2_q)       result_d = {1'b1, {(NBITS-1){1'b0}}};
    else if (zero2_q) result_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      v1_q   <= start ? 1'b1 : 1'b0;
      v2_q   <= v1_q;
      done_q <= v2_q;
      if (v2_q) result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    sgn1_q    <= in_sum[FBITS+10];
    inf1_q    <= in_sum[1];
    zero1_q   <= in_sum[0];
    hi1_q     <= hi_d;
    lo1_q     <= lo_d;
    k1_q      <= k_d;
    e1_q      <= scale[ES-1:0];
    frac1_q   <= in_sum[FBITS+1:2];
    sgn2_q    <= sgn1_q;
    inf2_q    <= inf1_q;
    zero2_q   <= zero1_q;
    hi2_q     <= hi1_q;
    lo2_q     <= lo1_q;
    mag2_q    <= mag_d;
    guard2_q  <= guard_d;
    sticky2_q <= sticky_d;
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_posit_encode_3_es2.sv
// tb/tb_posit_encode_3_es2.sv - directed and random checks of posit_encode_3_es2
module tb_posit_encode_3_es2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [41:0] in_sum = '0;
  logic [31:0] result;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] cur_exp = '0;
  logic [31:0] last_exp = '0;

  typedef struct { int due; logic [31:0] val; } exp_t;
  exp_t sb[$];

  posit_encode_3_es2 dut (
    .clk(clk), .reset(reset), .start(start), .in_sum(in_sum),
    .result(result), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [41:0] mk(input logic sgn, input logic [7:0] scale,
                                     input logic [30:0] frac, input logic inf, input logic zero);
    return {sgn, scale, frac, inf, zero};
  endfunction

  // Reference: write the posit bit string out as a list, then cut and round it.
  function automatic logic [31:0] model(input logic [41:0] s);
    int scale, e, k;
    bit q[$];
    longint mag;
    bit guard, sticky;
    logic [31:0] r;
    if (s[1]) return 32'h80000000;
    if (s[0]) return 32'h00000000;
    scale = int'($signed(s[40:33]));
    e = scale & 3;
    k = (scale - e) / 4;
    if (k > 30) mag = 64'h7FFFFFFF;
    else if (k < -30) mag = 1;
    else begin
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int i = 32; i >= 2; i--) q.push_back(s[i]);
      mag = 0;
      for (int i = 0; i < 31; i++) mag = mag * 2 + ((i < q.size()) ? longint'(q[i]) : 0);
      guard  = (q.size() > 31) ? q[31] : 1'b0;
      sticky = 1'b0;
      for (int i = 32; i < q.size(); i++) sticky |= q[i];
      if (guard && ((mag % 2) == 1 || sticky) && mag != 64'h7FFFFFFF) mag++;
      if (mag == 0) mag = 1;
    end
    r = 32'(mag);
    if (s[41]) r = -r;
    return r;
  endfunction

  task automatic step();
    logic was_start, was_reset;
    was_start = start;
    was_reset = reset;
    @(posedge clk);
    cyc++;
    if (was_reset) begin
      sb.delete();
      last_exp = '0;
    end else if (was_start === 1'b1) begin
      sb.push_back('{cyc + 2, cur_exp});
    end
    #1;
    if (was_reset) check("done_in_reset", {31'b0, done}, 32'd0);
    else if (done === 1'b1) begin
      if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
      else begin
        check("latency", cyc, sb[0].due);
        last_exp = sb[0].val;
        void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      check("missing_done", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    check("result", result, last_exp);
  endtask

  task automatic drive(input logic [41:0] v, input logic [31:0] exp);
    start   = 1'b1;
    in_sum  = v;
    cur_exp = exp;
    step();
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) step();
  endtask

  logic [41:0] dir_in  [14];
  logic [31:0] dir_exp [14];

  initial begin
    dir_in[0]  = mk(0, 8'h00, 31'h0,        0, 0); dir_exp[0]  = 32'h40000000;
    dir_in[1]  = mk(1, 8'h00, 31'h0,        0, 0); dir_exp[1]  = 32'hC0000000;
    dir_in[2]  = mk(0, 8'h00, 31'h40000000, 0, 0); dir_exp[2]  = 32'h44000000;
    dir_in[3]  = mk(0, 8'h04, 31'h0,        0, 0); dir_exp[3]  = 32'h60000000;
    dir_in[4]  = mk(0, 8'hFF, 31'h0,        0, 0); dir_exp[4]  = 32'h38000000;
    dir_in[5]  = mk(0, 8'h00, 31'h8,        0, 0); dir_exp[5]  = 32'h40000000;
    dir_in[6]  = mk(0, 8'h00, 31'h18,       0, 0); dir_exp[6]  = 32'h40000002;
    dir_in[7]  = mk(0, 8'h00, 31'hC,        0, 0); dir_exp[7]  = 32'h40000001;
    dir_in[8]  = mk(0, 8'h7F, 31'h0,        0, 0); dir_exp[8]  = 32'h7FFFFFFF;
    dir_in[9]  = mk(0, 8'h80, 31'h0,        0, 0); dir_exp[9]  = 32'h00000001;
    dir_in[10] = mk(1, 8'h7F, 31'h0,        0, 0); dir_exp[10] = 32'h80000001;
    dir_in[11] = mk(1, 8'h12, 31'h1234,     1, 1); dir_exp[11] = 32'h80000000;
    dir_in[12] = mk(1, 8'h12, 31'h1234,     0, 1); dir_exp[12] = 32'h00000000;
    dir_in[13] = mk(0, 8'h00, 31'h7FFFFFFF, 0, 0); dir_exp[13] = 32'h48000000;

    idle(3);
    reset = 1'b0;
    idle(2);

    drive(dir_in[0], dir_exp[0]);
    idle(4);
    drive(dir_in[1], dir_exp[1]);
    idle(4);
    for (int i = 2; i < 14; i++) drive(dir_in[i], dir_exp[i]);
    idle(4);

    for (int i = 0; i < 8; i++) begin
      logic [41:0] v;
      v = mk(1'($urandom), 8'($urandom), 31'($urandom), 1'b0, 1'b0);
      drive(v, model(v));
    end
    idle(4);

    drive(mk(0, 8'h05, 31'h1, 0, 0), model(mk(0, 8'h05, 31'h1, 0, 0)));
    drive(mk(1, 8'hF0, 31'h2, 0, 0), model(mk(1, 8'hF0, 31'h2, 0, 0)));
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(4);
    drive(mk(0, 8'h09, 31'h55555555, 0, 0), model(mk(0, 8'h09, 31'h55555555, 0, 0)));
    idle(4);

    for (int i = 0; i < 300; i++) begin
      logic [41:0] v;
      logic [7:0]  sc;
      sc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($signed($urandom_range(0, 250)) - 125);
      v = mk(1'($urandom), sc, 31'($urandom),
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      drive(v, model(v));
    end
    idle(6);
    check("drain", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
